closest_hit_reduce: RTL and testbench



---
 rtl/closest_hit_reduce_pkg.sv | 22 ++
 rtl/closest_hit_reduce_fifo.sv | 49 ++++
 rtl/closest_hit_reduce.sv | 125 ++++++++++++
 tb/tb_closest_hit_reduce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/closest_hit_reduce_pkg.sv
// closest_hit_reduce_pkg: shared types and constants for the closest-hit reducer.
// Define CLOSEST_HIT_STATS_EN to carry a per-ray triangle count in each record.
package closest_hit_reduce_pkg;

    localparam int TRI_IDX_W_D = 16;
    localparam int RAY_ID_W_D  = 8;

    localparam logic signed [31:0] FIP_MAX = 32'sh7fffffff;

    typedef enum logic {IDLE, ACCUM} state_t;

    typedef struct packed {
        logic [RAY_ID_W_D-1:0]  ray_id;
        logic                   hit;
        logic signed [31:0]     t;
        logic [TRI_IDX_W_D-1:0] tri_idx;
`ifdef CLOSEST_HIT_STATS_EN
        logic [TRI_IDX_W_D:0]   tri_count;
`endif
    } hit_rec_t;

endpackage

// File: rtl/closest_hit_reduce_fifo.sv
// hit_rec_fifo: synchronous FIFO of hit records; head is read straight from the register array.
module hit_rec_fifo
    import closest_hit_reduce_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  hit_rec_t din,
    input  logic     pop,
    output hit_rec_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    hit_rec_t        mem [DEPTH];
    logic [AW-1:0]   wr;
    logic [AW-1:0]   rd;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push
    assign do_push = push & (!full | pop);
    assign do_pop  = pop & !empty;
    assign head    = mem[rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/closest_hit_reduce.sv
// closest_hit_reduce: folds per-triangle intersection results into one closest-hit record per ray.
// Define CLOSEST_HIT_STATS_EN to report the per-ray triangle count on o_tri_count.
module closest_hit_reduce
    import closest_hit_reduce_pkg::*;
#(
    parameter int TRI_IDX_W = TRI_IDX_W_D,
    parameter int RAY_ID_W  = RAY_ID_W_D,
    parameter int OUT_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    input  logic                 i_result,
    input  logic signed [31:0]   i_t,
    input  logic [TRI_IDX_W-1:0] i_tri_idx,
    input  logic [RAY_ID_W-1:0]  i_ray_id,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [RAY_ID_W-1:0]  o_ray_id,
    output logic                 o_hit,
    output logic signed [31:0]   o_t,
    output logic [TRI_IDX_W-1:0] o_tri_idx,
    output logic [TRI_IDX_W:0]   o_tri_count,
    output logic                 o_overflow
);

    state_t               state;
    state_t               state_nxt;
    logic [RAY_ID_W-1:0]  ray_q;
    logic                 best_hit;
    logic signed [31:0]   best_t;
    logic [TRI_IDX_W-1:0] best_idx;
    logic                 first;
    logic                 better;
    logic [RAY_ID_W-1:0]  nxt_ray;
    logic                 nxt_hit;
    logic signed [31:0]   nxt_t;
    logic [TRI_IDX_W-1:0] nxt_idx;
    hit_rec_t             rec;
    hit_rec_t             head;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;

    // The merge always includes the current beat; a first beat merges against an empty best
    always_comb begin
        first     = state == IDLE;
        better    = i_result & (first | !best_hit | (i_t < best_t));
        nxt_ray   = first ? i_ray_id : ray_q;
        nxt_hit   = better | (!first & best_hit);
        nxt_t     = better ? i_t : (first ? FIP_MAX : best_t);
        nxt_idx   = better ? i_tri_idx : (first ? '0 : best_idx);
        state_nxt = state;
        if (i_valid) state_nxt = i_last ? IDLE : ACCUM;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ray_q    <= '0;
            best_hit <= 1'b0;
            best_t   <= FIP_MAX;
            best_idx <= '0;
        end else if (i_valid) begin
            ray_q    <= nxt_ray;
            best_hit <= nxt_hit;
            best_t   <= nxt_t;
            best_idx <= nxt_idx;
        end
    end

`ifdef CLOSEST_HIT_STATS_EN
    logic [TRI_IDX_W:0] cnt;
    logic [TRI_IDX_W:0] nxt_cnt;

    assign nxt_cnt = first ? (TRI_IDX_W+1)'(1) : (&cnt ? cnt : cnt + 1'b1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cnt <= '0;
        else if (i_valid) cnt <= nxt_cnt;
    end

    assign rec.tri_count = (TRI_IDX_W_D+1)'(nxt_cnt);
    assign o_tri_count   = (TRI_IDX_W+1)'(head.tri_count);
`else
    assign o_tri_count = '0;
`endif

    assign rec.ray_id  = RAY_ID_W_D'(nxt_ray);
    assign rec.hit     = nxt_hit;
    assign rec.t       = nxt_t;
    assign rec.tri_idx = TRI_IDX_W_D'(nxt_idx);

    assign push = i_valid & i_last;
    assign pop  = o_valid & i_ready;

    hit_rec_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (push),
        .din   (rec),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_valid   = !empty;
    assign o_ray_id  = RAY_ID_W'(head.ray_id);
    assign o_hit     = head.hit;
    assign o_t       = head.t;
    assign o_tri_idx = TRI_IDX_W'(head.tri_idx);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_overflow <= 1'b0;
        else if (push & full & !pop) o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_closest_hit_reduce.sv
// tb_closest_hit_reduce: directed checks of closest_hit_reduce with hand-computed expectations.
module tb_closest_hit_reduce;

    logic               clk = 1'b0;
    logic               rstn;
    logic               valid;
    logic               result;
    logic signed [31:0] t;
    logic [15:0]        tri_idx;
    logic [7:0]         ray_id;
    logic               last;
    logic               ready;
    logic               o_valid;
    logic [7:0]         o_ray_id;
    logic               o_hit;
    logic signed [31:0] o_t;
    logic [15:0]        o_tri_idx;
    logic [16:0]        o_tri_count;
    logic               o_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    closest_hit_reduce #(.TRI_IDX_W(16), .RAY_ID_W(8), .OUT_DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_valid     (valid),
        .i_result    (result),
        .i_t         (t),
        .i_tri_idx   (tri_idx),
        .i_ray_id    (ray_id),
        .i_last      (last),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_ray_id    (o_ray_id),
        .o_hit       (o_hit),
        .o_t         (o_t),
        .o_tri_idx   (o_tri_idx),
        .o_tri_count (o_tri_count),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat at a falling edge and return at the next falling edge
    task automatic step(input logic v, input logic res, input logic [31:0] tt,
                        input logic [15:0] idx, input logic [7:0] ray, input logic l);
        valid   = v;
        result  = res;
        t       = tt;
        tri_idx = idx;
        ray_id  = ray;
        last    = l;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic chk_rec(input string tag, input logic [7:0] ray, input logic hit,
                           input logic [31:0] tt, input logic [15:0] idx, input logic [16:0] cnt);
        chk({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
        chk({tag, "_ray"}, 64'(o_ray_id), 64'(ray));
        chk({tag, "_hit"}, 64'(o_hit), 64'(hit));
        chk({tag, "_t"}, 64'($unsigned(o_t)), 64'(tt));
        chk({tag, "_idx"}, 64'(o_tri_idx), 64'(idx));
`ifdef CLOSEST_HIT_STATS_EN
        chk({tag, "_cnt"}, 64'(o_tri_count), 64'(cnt));
`else
        chk({tag, "_cnt"}, 64'(o_tri_count), 64'(cnt & 17'h0));
`endif
    endtask

    initial begin
        rstn  = 1'b0;
        ready = 1'b1;
        idle();
        idle();
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_ovf", 64'(o_overflow), 0);
        chk("rst_hit", 64'(o_hit), 0);
        chk("rst_t", 64'($unsigned(o_t)), 0);
        chk("rst_idx", 64'(o_tri_idx), 0);
        chk("rst_ray", 64'(o_ray_id), 0);
        chk("rst_cnt", 64'(o_tri_count), 0);
        rstn = 1'b1;
        idle();

        // closest of several hits, last beat a miss
        step(1, 1, 32'h30000, 0, 3, 0);
        step(1, 1, 32'h18000, 1, 3, 0);
        step(1, 1, 32'h20000, 2, 3, 0);
        chk("r3_pre_valid", 64'(o_valid), 0);
        step(1, 0, 32'h0, 3, 3, 1);
        chk_rec("r3", 8'd3, 1, 32'h18000, 16'd1, 17'd4);
        idle();
        chk("r3_drained", 64'(o_valid), 0);

        // all-miss ray: t values on misses must be ignored
        step(1, 0, 32'h5, 4, 4, 0);
        step(1, 0, 32'h1, 5, 4, 0);
        step(1, 0, 32'h2, 6, 4, 1);
        chk_rec("miss", 8'd4, 0, 32'h7fffffff, 16'd0, 17'd3);
        idle();

        // equal t keeps the earlier triangle
        step(1, 1, 32'h10000, 5, 5, 0);
        step(1, 1, 32'h20000, 7, 5, 0);
        step(1, 1, 32'h10000, 9, 5, 1);
        chk_rec("tie", 8'd5, 1, 32'h10000, 16'd5, 17'd3);
        idle();

        // negative t is closer under signed comparison
        step(1, 1, 32'h10000, 1, 6, 0);
        step(1, 1, 32'hffff8000, 2, 6, 1);
        chk_rec("neg", 8'd6, 1, 32'hffff8000, 16'd2, 17'd2);
        idle();

        // back-to-back single-beat rays
        step(1, 1, 32'h100, 4, 1, 1);
        chk_rec("b2b1", 8'd1, 1, 32'h100, 16'd4, 17'd1);
        step(1, 0, 32'h0, 5, 2, 1);
        chk_rec("b2b2", 8'd2, 0, 32'h7fffffff, 16'd0, 17'd1);
        step(1, 1, 32'h300, 6, 3, 1);
        chk_rec("b2b3", 8'd3, 1, 32'h300, 16'd6, 17'd1);
        idle();
        chk("b2b_drained", 64'(o_valid), 0);

        // FIFO full with consumer stalled: third record dropped
        ready = 1'b0;
        step(1, 1, 32'h11, 1, 1, 1);
        step(1, 1, 32'h22, 2, 2, 1);
        chk("ovf_before", 64'(o_overflow), 0);
        step(1, 1, 32'h33, 3, 3, 1);
        chk("ovf_set", 64'(o_overflow), 1);
        chk_rec("hold1", 8'd1, 1, 32'h11, 16'd1, 17'd1);
        idle();
        chk_rec("stall1", 8'd1, 1, 32'h11, 16'd1, 17'd1);
        ready = 1'b1;
        idle();
        chk_rec("drain2", 8'd2, 1, 32'h22, 16'd2, 17'd1);
        idle();
        chk("drain_empty", 64'(o_valid), 0);
        chk("ovf_sticky", 64'(o_overflow), 1);

        // reset mid-ray discards the partial accumulation
        step(1, 1, 32'h100, 0, 7, 0);
        step(1, 1, 32'h80, 1, 7, 0);
        valid = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(o_valid), 0);
        chk("mid_rst_ovf", 64'(o_overflow), 0);
        rstn = 1'b1;
        step(1, 1, 32'h8000, 2, 8, 1);
        chk_rec("r8", 8'd8, 1, 32'h8000, 16'd2, 17'd1);
        idle();
        chk("r8_only", 64'(o_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
